// File: rtl/decoder_5x32.sv
// Registered 5-to-32 one-hot decoder: one cycle from sampled D/E to O, no backpressure.
// Unknown select or deasserted enable decodes to all-zero so X never reaches O.
module decoder_5x32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  D,
  input  logic        E,
  output logic [31:0] O
);

  logic [31:0] decode;

  // Equality against an unknown D is never true, so X/Z select falls through to zero.
  always_comb begin
    decode = '0;
    if (E) begin
      for (int i = 0; i < 32; i++) begin
        if (D == i[4:0]) begin
          decode[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O <= '0;
    end else begin
      O <= decode;
    end
  end

endmodule

// File: tb/tb_decoder_5x32.sv
// Self-checking bench for decoder_5x32: directed cases plus random E/D stream vs a shift-based model.
module tb_decoder_5x32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  D;
  logic        E;
  logic [31:0] O;

  int errors;
  int checks;

  decoder_5x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .E     (E),
    .O     (O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: bit D set when enabled and D is a known index, otherwise zero.
  function automatic logic [31:0] ref_decode(input logic en, input logic [4:0] sel);
    if (en === 1'b1 && !$isunknown(sel))
      return 32'd1 << sel;
    return 32'd0;
  endfunction

  // Drive inputs, take one rising edge, check O against the model and the one-hot rule.
  task automatic step(input string tag, input logic en, input logic [4:0] sel);
    logic [31:0] exp;
    E = en;
    D = sel;
    exp = ref_decode(E, D);
    @(posedge clk);
    #1;
    chk(tag, O, exp);
    chk({tag, "_onehot"}, {31'd0, $onehot0(O)}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [4:0]  sweep [6];
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    E = 1'b1;
    D = 5'd7;
    #1;
    chk("reset_async", O, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_edge", O, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable off
    step("en_off_0", 1'b0, 5'b00000);
    step("en_off_21", 1'b0, 5'b10101);

    // Sweep of representative indices
    sweep = '{5'd0, 5'd1, 5'd2, 5'd15, 5'd21, 5'd31};
    foreach (sweep[i]) step($sformatf("sweep_%0d", sweep[i]), 1'b1, sweep[i]);
    chk("sweep_last_const", O, 32'h8000_0000);

    // Enable drop
    step("drop_on", 1'b1, 5'b01010);
    chk("drop_on_const", O, 32'h0000_0400);
    step("drop_off", 1'b0, 5'b01010);

    // Inputs changing between edges must not disturb O
    step("hold_setup", 1'b1, 5'd9);
    held = O;
    D = 5'd17;
    E = 1'b0;
    #3;
    chk("hold_between_edges", O, held);

    // Unknown select
    step("unknown_en0", 1'b0, 5'bxxxxx);
    step("unknown_en1", 1'b1, 5'bxxxxx);

    // Async reset mid-cycle
    step("pre_reset", 1'b1, 5'd31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_cycle", O, 32'd0);
    E = 1'b1;
    D = 5'd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_held", O, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_release", 1'b1, 5'd3);
    chk("reset_release_const", O, 32'h0000_0008);

    // Exhaustive select values
    for (int i = 0; i < 32; i++) step($sformatf("exh_%0d", i), 1'b1, 5'(i));

    // Random stream, enable high roughly 3 of 4 cycles
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(3) != 0), 5'($urandom_range(31)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_5x32.md
DECODER_5X32 -- requirements
Module: decoder_5x32

Interface
REQ-001 Parameters: none; widths fixed at 5-bit select and 32-bit output.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-005 Port `D`: input, 5 bits, binary select index, 0..31.
REQ-006 Port `E`: input, 1 bit, decode enable, active-high.
REQ-007 Port `O`: output, 32 bits, registered one-hot decode result.

Function
REQ-008 The module SHALL, on each rising `clk` edge with `rst_n`=1 and `E`=1, load `O` with bit `D` set and all other 31 bits cleared.
- D=0 -> 32'h0000_0001
- D=31 -> 32'h8000_0000
REQ-009 The module SHALL, on each rising `clk` edge with `rst_n`=1 and `E`=0, load `O` with 32'h0000_0000, regardless of `D`, including X/Z on `D`.
REQ-010 Latency SHALL be exactly one clock cycle from sampled `E`/`D` to `O`; there is no combinational path from `E` or `D` to `O`.
REQ-011 `O` SHALL be one-hot or all-zero at all times; two or more set bits is illegal.
REQ-012 The module SHALL, with `E`=1 and any bit of `D` X or Z at the sampling edge, load `O` with 32'h0000_0000; it SHALL NOT propagate X.
REQ-013 `O` SHALL hold its value between edges; changes of `D`/`E` between edges have no effect until the next rising edge.
REQ-014 A change of `E` from 1 to 0 SHALL clear `O` on the next edge; a change from 0 to 1 SHALL produce the decode of the `D` sampled on that edge.
REQ-015 Back-to-back different `D` values with `E`=1 SHALL produce a new one-hot value every cycle, with no intermediate cycle.
REQ-016 The module SHALL contain no handshake, backpressure or internal FSM; it is a registered decoder only.

Reset
REQ-017 `rst_n`=0 SHALL force `O` to 32'h0000_0000 immediately, without waiting for a clock edge.
REQ-018 `O` SHALL remain 32'h0000_0000 while `rst_n`=0, regardless of `E`, `D` and `clk`.
REQ-019 Reset release SHALL be synchronous to `clk`; the first rising edge with `rst_n`=1 performs a normal decode.
REQ-020 Reset asserted mid-operation SHALL clear `O` within the same cycle, with no residual one-hot bit.

Verification
REQ-021 Enable off: `E`=0, D=5'b00000 and then D=5'b10101 over two edges -> `O`=32'h0000_0000 after each edge.
REQ-022 Sweep: `E`=1, D=0,1,2,15,21,31 on consecutive edges -> `O` = 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_8000, 32'h0020_0000, 32'h8000_0000, each one cycle after its D.
REQ-023 Enable drop: `E`=1, D=5'b01010 -> `O`=32'h0000_0400; then `E`=0 -> `O`=32'h0000_0000 on the next edge.
REQ-024 Unknown select: `E`=0, D=5'bxxxxx -> `O`=0; then `E`=1, D=5'bxxxxx -> `O`=0, with no X bits.
REQ-025 Async reset: with `O`=32'h8000_0000, assert `rst_n`=0 mid-cycle -> `O`=0 before the next edge; hold `E`=1, D=3 across edges -> `O` stays 0; release `rst_n` -> next edge gives 32'h0000_0008.
REQ-026 Exhaustive check: all 32 D values with `E`=1, plus random E/D streams -> `O` equals the one-cycle-delayed reference decode, and a one-hot-or-zero assertion holds every cycle.
